counter_core: RTL and testbench

COUNTER_CORE -- requirements
Module: counter_core

---
 rtl/counter_pkg.sv | 45 ++++
 rtl/updown_counter.sv | 47 ++++
 rtl/counter_core.sv | 82 ++++++++
 tb/tb_counter_core.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and types for the counter_core register block.
// Holds register map indices, config bit positions and the status threshold.
package counter_pkg;

  localparam int unsigned REG_COUNT = 4;
  localparam int unsigned DataWidth = 32;

  // Register map indices, one write/read strobe bit per register
  localparam int unsigned RegCounter = 0;
  localparam int unsigned RegConfig  = 1;
  localparam int unsigned RegStatus  = 2;
  localparam int unsigned RegPending = 3;

  // Config register bit positions
  localparam int unsigned CfgEnableBit = 0;
  localparam int unsigned CfgDirBit    = 1;
  localparam int unsigned CfgIrqEnBit  = 2;
  localparam int unsigned CfgWidth     = 3;

  localparam logic [DataWidth-1:0] THRESHOLD = 32'd1000;

  typedef struct packed {
    logic irq_en;
    logic dir_up;
    logic enable;
  } cfg_t;

  function automatic cfg_t unpack_cfg(input logic [CfgWidth-1:0] bits);
    cfg_t c;
    c.enable = bits[CfgEnableBit];
    c.dir_up = bits[CfgDirBit];
    c.irq_en = bits[CfgIrqEnBit];
    return c;
  endfunction

  function automatic logic [DataWidth-1:0] pack_cfg(input cfg_t c);
    logic [DataWidth-1:0] w;
    w               = '0;
    w[CfgEnableBit] = c.enable;
    w[CfgDirBit]    = c.dir_up;
    w[CfgIrqEnBit]  = c.irq_en;
    return w;
  endfunction

endpackage

// File: rtl/updown_counter.sv
// Load/step up-down counter with a one-cycle wrap strobe.
// A load takes priority over a step and suppresses wrap detection.
module updown_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             step_i,
  input  logic             up_i,
  output logic [Width-1:0] count_o,
  output logic             wrap_o
);

  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] count_q, count_d;

  // wrap_o is valid in the cycle before the edge that performs the wrapping step
  always_comb begin
    count_d = count_q;
    wrap_o  = 1'b0;
    if (load_i) begin
      count_d = load_val_i;
    end else if (step_i) begin
      if (up_i) begin
        count_d = count_q + One;
        wrap_o  = &count_q;
      end else begin
        count_d = count_q - One;
        wrap_o  = ~|count_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/counter_core.sv
// Four-register counter block: counter, config, status and a W1C wrap-pending flag
// with a registered level interrupt.
module counter_core
  import counter_pkg::*;
(
  input  logic                                clk,
  input  logic                                reset,
  input  logic [REG_COUNT-1:0]                write_en,
  input  logic [REG_COUNT-1:0]                read_en,
  input  logic [DataWidth-1:0]                data_in,
  output logic [REG_COUNT-1:0][DataWidth-1:0] data_out,
  output logic                                irq_out
);

  cfg_t                 cfg_q, cfg_d;
  logic                 pending_q, pending_d;
  logic                 irq_q, irq_d;
  logic [DataWidth-1:0] count;
  logic                 wrap;
  logic                 status_below;

  // Reads are side-effect free, so the strobe is not needed internally
  logic unused_read_en;
  assign unused_read_en = ^read_en;

  updown_counter #(
    .Width (DataWidth)
  ) u_updown_counter (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (write_en[RegCounter]),
    .load_val_i (data_in),
    .step_i     (cfg_q.enable),
    .up_i       (cfg_q.dir_up),
    .count_o    (count),
    .wrap_o     (wrap)
  );

  always_comb begin
    cfg_d = cfg_q;
    if (write_en[RegConfig]) begin
      cfg_d = unpack_cfg(data_in[CfgWidth-1:0]);
    end
  end

  // Set wins over a coincident W1C clear
  always_comb begin
    pending_d = pending_q;
    if (wrap) begin
      pending_d = 1'b1;
    end else if (write_en[RegPending] && data_in[0]) begin
      pending_d = 1'b0;
    end
  end

  assign irq_d = pending_q & cfg_q.irq_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_q     <= '0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      cfg_q     <= cfg_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
    end
  end

  assign status_below = (count < THRESHOLD);

  always_comb begin
    data_out             = '0;
    data_out[RegCounter] = count;
    data_out[RegConfig]  = pack_cfg(cfg_q);
    data_out[RegStatus]  = {{(DataWidth-1){1'b0}}, status_below};
    data_out[RegPending] = {{(DataWidth-1){1'b0}}, pending_q};
  end

  assign irq_out = irq_q;

endmodule

// File: tb/tb_counter_core.sv
// Directed bench for counter_core: one-cycle vector table plus hand-written
// asynchronous reset sequences.
module tb_counter_core;

  logic              clk;
  logic              reset;
  logic [3:0]        write_en;
  logic [3:0]        read_en;
  logic [31:0]       data_in;
  logic [3:0][31:0]  data_out;
  logic              irq_out;

  int checks;
  int passed;

  typedef struct {
    logic [3:0]  we;
    logic [31:0] din;
    logic [31:0] cnt;
    logic [2:0]  cfg;
    logic        st;
    logic        pend;
    logic        irq;
  } vec_t;

  vec_t vecs[$];

  counter_core dut (
    .clk      (clk),
    .reset    (reset),
    .write_en (write_en),
    .read_en  (read_en),
    .data_in  (data_in),
    .data_out (data_out),
    .irq_out  (irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic [31:0] cnt, input logic [2:0] cfg,
                           input logic st, input logic pend, input logic irq);
    chk({tag, ".counter"}, data_out[0], cnt);
    chk({tag, ".config"},  data_out[1], {29'b0, cfg});
    chk({tag, ".status"},  data_out[2], {31'b0, st});
    chk({tag, ".pending"}, data_out[3], {31'b0, pend});
    chk({tag, ".irq"},     {31'b0, irq_out}, {31'b0, irq});
  endtask

  task automatic add(input logic [3:0] we, input logic [31:0] din, input logic [31:0] cnt,
                     input logic [2:0] cfg, input logic st, input logic pend, input logic irq);
    vec_t v;
    v.we = we; v.din = din; v.cnt = cnt; v.cfg = cfg; v.st = st; v.pend = pend; v.irq = irq;
    vecs.push_back(v);
  endtask

  initial begin
    checks   = 0;
    passed   = 0;
    reset    = 1'b0;
    write_en = '0;
    read_en  = '0;
    data_in  = '0;

    //   we       din           cnt           cfg st pend irq
    add(4'b0010, 32'h3,        32'h0,        3'd3, 1, 0, 0); // step uses old config
    add(4'b0000, 32'h0,        32'h1,        3'd3, 1, 0, 0);
    add(4'b0000, 32'h0,        32'h2,        3'd3, 1, 0, 0);
    add(4'b0000, 32'h0,        32'h3,        3'd3, 1, 0, 0);
    add(4'b0001, 32'h10,       32'h10,       3'd3, 1, 0, 0); // write beats step
    add(4'b0010, 32'h0,        32'h11,       3'd0, 1, 0, 0);
    add(4'b0001, 32'd999,      32'd999,      3'd0, 1, 0, 0);
    add(4'b0010, 32'h3,        32'd999,      3'd3, 1, 0, 0);
    add(4'b0000, 32'h0,        32'd1000,     3'd3, 0, 0, 0); // threshold boundary
    add(4'b0010, 32'h0,        32'd1001,     3'd0, 0, 0, 0);
    add(4'b0001, 32'hFFFFFFFE, 32'hFFFFFFFE, 3'd0, 0, 0, 0);
    add(4'b0010, 32'h7,        32'hFFFFFFFE, 3'd7, 0, 0, 0);
    add(4'b0000, 32'h0,        32'hFFFFFFFF, 3'd7, 0, 0, 0);
    add(4'b0000, 32'h0,        32'h0,        3'd7, 1, 1, 0); // up wrap
    add(4'b0000, 32'h0,        32'h1,        3'd7, 1, 1, 1);
    add(4'b1000, 32'h0,        32'h2,        3'd7, 1, 1, 1); // W1C with 0: no effect
    add(4'b1000, 32'h1,        32'h3,        3'd7, 1, 0, 1);
    add(4'b0000, 32'h0,        32'h4,        3'd7, 1, 0, 0);
    add(4'b0010, 32'h0,        32'h5,        3'd0, 1, 0, 0);
    add(4'b0001, 32'h0,        32'h0,        3'd0, 1, 0, 0);
    add(4'b0010, 32'h5,        32'h0,        3'd5, 1, 0, 0);
    add(4'b0000, 32'h0,        32'hFFFFFFFF, 3'd5, 0, 1, 0); // down wrap
    add(4'b1000, 32'h1,        32'hFFFFFFFE, 3'd5, 0, 0, 1);
    add(4'b0000, 32'h0,        32'hFFFFFFFD, 3'd5, 0, 0, 0);
    add(4'b0010, 32'h4,        32'hFFFFFFFC, 3'd4, 0, 0, 0);
    add(4'b0001, 32'h0,        32'h0,        3'd4, 1, 0, 0);
    add(4'b0000, 32'h0,        32'h0,        3'd4, 1, 0, 0); // disabled: no wrap
    add(4'b0010, 32'h3,        32'h0,        3'd3, 1, 0, 0);
    add(4'b0001, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd3, 0, 0, 0);
    add(4'b1000, 32'h1,        32'h0,        3'd3, 1, 1, 0); // set beats clear
    add(4'b0100, 32'hFFFFFFFF, 32'h1,        3'd3, 1, 1, 0); // status is read-only
    add(4'b1000, 32'h1,        32'h2,        3'd3, 1, 0, 0);
    add(4'b0001, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd3, 0, 0, 0);
    add(4'b0001, 32'h5,        32'h5,        3'd3, 1, 0, 0); // load over wrap point
    add(4'b0010, 32'hFFFFFFFF, 32'h6,        3'd7, 1, 0, 0); // upper config bits read 0
    add(4'b0000, 32'h0,        32'h7,        3'd7, 1, 0, 0);
    add(4'b0001, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd7, 0, 0, 0);
    add(4'b0000, 32'h0,        32'h0,        3'd7, 1, 1, 0);
    add(4'b0000, 32'h0,        32'h1,        3'd7, 1, 1, 1);

    #12;
    check_all("reset", 32'h0, 3'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      write_en = vecs[i].we;
      data_in  = vecs[i].din;
      read_en  = 4'(1 << (i % 4));
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].cfg, vecs[i].st,
                vecs[i].pend, vecs[i].irq);
    end

    // Reset dropped between edges while counting with pending and irq high
    @(negedge clk);
    write_en = '0;
    data_in  = '0;
    @(posedge clk);
    #1;
    chk("pre_rst.counter", data_out[0], 32'h2);
    chk("pre_rst.irq", {31'b0, irq_out}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check_all("async_rst", 32'h0, 3'd0, 1'b1, 1'b0, 1'b0);

    // Writes are ignored while reset is held across an edge
    @(negedge clk);
    write_en = 4'b0011;
    data_in  = 32'h55;
    @(posedge clk);
    #1;
    check_all("rst_hold", 32'h0, 3'd0, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    write_en = '0;
    data_in  = '0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_rst", 32'h0, 3'd0, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
